// File: rtl/mem_sram_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_sram_controller_if
// Brief    : MEM-stage request bus and external 16-bit SRAM pins, bundled.
// Revision : 1.0
// ============================================================================
interface mem_sram_controller_if #(
  parameter int ADDRESS_LEN   = 32,
  parameter int DATA_LEN      = 32,
  parameter int SRAM_ADDR_LEN = 18,
  parameter int SRAM_DATA_LEN = 16
);
  logic                     mem_r_en;
  logic                     mem_w_en;
  logic [ADDRESS_LEN-1:0]   address;
  logic [DATA_LEN-1:0]      write_data;
  logic [DATA_LEN-1:0]      read_data;
  logic                     ready;
  logic [SRAM_ADDR_LEN-1:0] sram_addr;
  logic [SRAM_DATA_LEN-1:0] sram_dq_out;
  logic [SRAM_DATA_LEN-1:0] sram_dq_in;
  logic                     sram_dq_oe;
  logic                     sram_we_n;
  logic                     sram_oe_n;

  // master: pipeline plus SRAM device side; slave: the controller
  modport master (
    output mem_r_en, mem_w_en, address, write_data, sram_dq_in,
    input  read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n, sram_oe_n
  );

  modport slave (
    input  mem_r_en, mem_w_en, address, write_data, sram_dq_in,
    output read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n, sram_oe_n
  );
endinterface
`default_nettype wire

// File: rtl/mem_sram_controller.sv
`default_nettype none
// ============================================================================
// Module   : mem_sram_controller
// Brief    : Splits 32-bit MEM-stage loads/stores into two timed 16-bit
//            asynchronous SRAM accesses and stalls the pipeline meanwhile.
// Revision : 1.0
// ============================================================================
module mem_sram_controller #(
  parameter int ADDRESS_LEN   = 32,
  parameter int DATA_LEN      = 32,
  parameter int SRAM_ADDR_LEN = 18,
  parameter int SRAM_DATA_LEN = 16,
  parameter int BASE_ADDR     = 1024,
  parameter int WAIT_CYCLES   = 3
) (
  input wire logic               clk,
  input wire logic               rst,
  mem_sram_controller_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [ADDRESS_LEN-1:0] c_base_addr = ADDRESS_LEN'(BASE_ADDR);
  localparam logic [3:0]             c_last_cnt  = 4'(WAIT_CYCLES - 1);
  localparam int                     c_idx_len   = SRAM_ADDR_LEN - 1;

  state_t                   r_state;
  logic [3:0]               r_wait_cnt;
  logic                     r_is_write;
  logic [c_idx_len-1:0]     r_word_idx;
  logic [SRAM_DATA_LEN-1:0] r_wdata_hi;
  logic [SRAM_DATA_LEN-1:0] r_low_half;
  logic [DATA_LEN-1:0]      r_read_data;
  logic [SRAM_ADDR_LEN-1:0] r_sram_addr;
  logic [SRAM_DATA_LEN-1:0] r_dq_out;
  logic                     r_dq_oe;
  logic                     r_we_n;
  logic                     r_oe_n;

  logic                     w_req;
  logic [ADDRESS_LEN-1:0]   w_byte_off;
  logic [c_idx_len-1:0]     w_word_idx;
  logic [3:0]               w_next_cnt;
  logic                     w_phase_end;
  logic                     w_ready;
  logic                     w_unused_off;

  assign w_req        = bus.mem_r_en | bus.mem_w_en;
  assign w_byte_off   = bus.address - c_base_addr;
  assign w_word_idx   = w_byte_off[c_idx_len+1:2];
  assign w_unused_off = ^{w_byte_off[ADDRESS_LEN-1:c_idx_len+2], w_byte_off[1:0]};
  assign w_next_cnt   = r_wait_cnt + 4'd1;
  assign w_phase_end  = (r_wait_cnt == c_last_cnt);

  always_comb begin
    w_ready = 1'b1;
    case (r_state)
      S_IDLE:         w_ready = !w_req;
      S_LOW, S_HIGH:  w_ready = 1'b0;
      default:        w_ready = 1'b1;
    endcase
  end

  // Strobes are registered one edge ahead, so each phase cycle sees the
  // value computed from the counter value it will hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_wait_cnt  <= 4'd0;
      r_is_write  <= 1'b0;
      r_word_idx  <= '0;
      r_wdata_hi  <= '0;
      r_low_half  <= '0;
      r_read_data <= '0;
      r_sram_addr <= '0;
      r_dq_out    <= '0;
      r_dq_oe     <= 1'b0;
      r_we_n      <= 1'b1;
      r_oe_n      <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_state     <= S_LOW;
            r_wait_cnt  <= 4'd0;
            r_is_write  <= bus.mem_w_en;
            r_word_idx  <= w_word_idx;
            r_wdata_hi  <= bus.write_data[2*SRAM_DATA_LEN-1:SRAM_DATA_LEN];
            r_sram_addr <= {w_word_idx, 1'b0};
            r_dq_out    <= bus.write_data[SRAM_DATA_LEN-1:0];
            r_dq_oe     <= bus.mem_w_en;
            r_we_n      <= !bus.mem_w_en;
            r_oe_n      <= bus.mem_w_en;
          end
        end
        S_LOW: begin
          if (w_phase_end) begin
            r_state     <= S_HIGH;
            r_wait_cnt  <= 4'd0;
            r_sram_addr <= {r_word_idx, 1'b1};
            r_dq_out    <= r_wdata_hi;
            r_we_n      <= !r_is_write;
            if (!r_is_write) begin
              r_low_half <= bus.sram_dq_in;
            end
          end else begin
            r_wait_cnt <= w_next_cnt;
            r_we_n     <= !r_is_write || (w_next_cnt == c_last_cnt);
          end
        end
        S_HIGH: begin
          if (w_phase_end) begin
            r_state    <= S_DONE;
            r_wait_cnt <= 4'd0;
            r_dq_oe    <= 1'b0;
            r_we_n     <= 1'b1;
            r_oe_n     <= 1'b1;
            if (!r_is_write) begin
              r_read_data <= {bus.sram_dq_in, r_low_half};
            end
          end else begin
            r_wait_cnt <= w_next_cnt;
            r_we_n     <= !r_is_write || (w_next_cnt == c_last_cnt);
          end
        end
        S_DONE: begin
          // Never restarts here: the pipeline may still be holding the request.
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ready       = w_ready;
  assign bus.read_data   = r_read_data;
  assign bus.sram_addr   = r_sram_addr;
  assign bus.sram_dq_out = r_dq_out;
  assign bus.sram_dq_oe  = r_dq_oe;
  assign bus.sram_we_n   = r_we_n;
  assign bus.sram_oe_n   = r_oe_n;

endmodule
`default_nettype wire

// File: tb/tb_mem_sram_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_sram_controller
// Brief    : Randomized and directed bench with a word-level reference model.
// Revision : 1.0
// ============================================================================
module tb_mem_sram_controller;
  localparam int W    = 3;
  localparam int BASE = 1024;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_sram_controller_if bus ();

  mem_sram_controller #(
    .BASE_ADDR   (BASE),
    .WAIT_CYCLES (W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Asynchronous SRAM device: reads combinational, writes while WE# is low.
  logic [15:0] sram [0:262143];
  assign bus.sram_dq_in = bus.sram_oe_n ? 16'h0000 : sram[bus.sram_addr];
  always @(posedge clk) begin
    if (!bus.sram_we_n && bus.sram_dq_oe) sram[bus.sram_addr] <= bus.sram_dq_out;
  end

  // Reference: 32-bit words keyed by 17-bit word index, plus expected read_data
  logic [31:0] ref_words [int unsigned];
  logic [31:0] exp_rd;
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [16:0] word_key(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - 32'(BASE);
    return off[18:2];
  endfunction

  function automatic logic [31:0] ref_read(input logic [16:0] k);
    return ref_words.exists(32'(k)) ? ref_words[32'(k)] : 32'h0;
  endfunction

  task automatic access(input bit wr, input bit rd, input logic [31:0] addr,
                        input logic [31:0] data, input string tag);
    int cyc, errs, ph, pos;
    bit done;
    logic [16:0] k;
    logic [17:0] exp_addr;
    k = word_key(addr);
    @(negedge clk);
    bus.mem_w_en = wr; bus.mem_r_en = rd; bus.address = addr; bus.write_data = data;
    #1;
    cyc = 0; errs = 0; done = 1'b0;
    while (!done && cyc <= 40) begin
      if (cyc >= 1 && cyc <= 2*W) begin
        ph  = (cyc - 1) / W;
        pos = (cyc - 1) % W;
        exp_addr = {k, ph[0]};
        if (bus.sram_addr !== exp_addr) errs++;
        if (wr) begin
          if (bus.sram_we_n !== (pos == W-1)) errs++;
          if (bus.sram_oe_n !== 1'b1 || bus.sram_dq_oe !== 1'b1) errs++;
          if (bus.sram_dq_out !== (ph == 1 ? data[31:16] : data[15:0])) errs++;
        end else begin
          if (bus.sram_we_n !== 1'b1 || bus.sram_oe_n !== 1'b0 || bus.sram_dq_oe !== 1'b0) errs++;
        end
      end else if (bus.sram_we_n !== 1'b1 || bus.sram_oe_n !== 1'b1 || bus.sram_dq_oe !== 1'b0) begin
        errs++;
      end
      if (bus.ready === 1'b1) done = 1'b1;
      else begin
        @(negedge clk); #1;
        cyc++;
      end
    end
    check({tag, "_latency"}, 32'(cyc), 32'(2*W+1));
    check({tag, "_phase_sig"}, 32'(errs), 32'd0);
    if (wr) begin
      ref_words[32'(k)] = data;
      check({tag, "_sram_lo"}, {16'h0, sram[{k, 1'b0}]}, {16'h0, data[15:0]});
      check({tag, "_sram_hi"}, {16'h0, sram[{k, 1'b1}]}, {16'h0, data[31:16]});
    end else begin
      exp_rd = ref_read(k);
    end
    check({tag, "_read_data"}, bus.read_data, exp_rd);
  endtask

  task automatic idle(input int n, input string tag);
    int errs;
    errs = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.mem_w_en = 1'b0; bus.mem_r_en = 1'b0;
      #1;
      if (bus.ready !== 1'b1 || bus.read_data !== exp_rd) errs++;
      if (bus.sram_we_n !== 1'b1 || bus.sram_oe_n !== 1'b1 || bus.sram_dq_oe !== 1'b0) errs++;
    end
    check({tag, "_idle"}, 32'(errs), 32'd0);
  endtask

  initial begin
    logic [31:0] a, d;
    logic [16:0] k;
    int op;
    for (int i = 0; i < 262144; i++) sram[i] = 16'h0;
    exp_rd = 32'h0;
    bus.mem_r_en = 1'b0; bus.mem_w_en = 1'b0;
    bus.address = 32'h0; bus.write_data = 32'h0;
    rst = 1'b1;
    #2;
    check("rst_read_data", bus.read_data, 32'h0);
    check("rst_sram_addr", {14'h0, bus.sram_addr}, 32'h0);
    check("rst_dq_out", {16'h0, bus.sram_dq_out}, 32'h0);
    check("rst_strobes", {28'h0, bus.ready, bus.sram_dq_oe, bus.sram_we_n, bus.sram_oe_n}, 32'hB);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    access(1, 0, 32'd1024, 32'hDEADBEEF, "t1_store");
    access(0, 1, 32'd1024, 32'h0, "t2_load");
    idle(5, "t2_hold");
    access(1, 0, 32'd1030, 32'h12345678, "t3_store");
    access(0, 1, 32'd1028, 32'h0, "t3_load");
    access(0, 1, 32'd1024, 32'h0, "t4_load");
    access(1, 0, 32'd1032, 32'hCAFEF00D, "t4_b2b");
    idle(1, "t4_gap");
    access(1, 1, 32'd1036, 32'hA5A55A5A, "t5_both");
    idle(2, "t5_hold");

    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 3) == 0)
        a = 32'(BASE) - 32'(4 * $urandom_range(1, 8)) + 32'($urandom_range(0, 3));
      else
        a = 32'(BASE) + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
      d  = $urandom;
      op = $urandom_range(0, 2);
      access(op != 1, op != 0, a, d, "rnd");
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2), "rnd");
    end

    // Reset during the HIGH phase of a store to a word with known contents
    access(1, 0, 32'd1040, 32'h11112222, "t6_prime");
    k = word_key(32'd1040);
    @(negedge clk);
    bus.mem_w_en = 1'b1; bus.mem_r_en = 1'b0;
    bus.address = 32'd1040; bus.write_data = 32'h33334444;
    repeat (W + 1) @(negedge clk);
    #1;
    check("t6_in_high", {14'h0, bus.sram_addr}, {14'h0, k, 1'b1});
    rst = 1'b1;
    bus.mem_w_en = 1'b0;
    #1;
    check("t6_rst_read_data", bus.read_data, 32'h0);
    check("t6_rst_sram_addr", {14'h0, bus.sram_addr}, 32'h0);
    check("t6_rst_strobes", {28'h0, bus.ready, bus.sram_dq_oe, bus.sram_we_n, bus.sram_oe_n}, 32'hB);
    @(negedge clk);
    rst = 1'b0;
    exp_rd = 32'h0;
    ref_words[32'(k)] = {16'h1111, 16'h4444};
    check("t6_sram_lo", {16'h0, sram[{k, 1'b0}]}, 32'h4444);
    check("t6_sram_hi", {16'h0, sram[{k, 1'b1}]}, 32'h1111);
    access(0, 1, 32'd1040, 32'h0, "t6_load");
    idle(2, "end");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
